// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: vending transaction sequencer.
// Locks a selection, takes coins, dispenses, holds change/refund.
module vend_txn_ctrl #(
    parameter int P1         = 12,
    parameter int P2         = 14,
    parameter int P3         = 2,
    parameter int P4         = 3,
    parameter int STOCK_INIT = 9,
    parameter int TIMEOUT    = 500_000_000,
    parameter int HOLD       = 300_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw,
    input  logic [4:0]  bt_edge,
    input  logic        restock,
    output logic [2:0]  state,
    output logic [1:0]  sel,
    output logic [3:0]  price,
    output logic [4:0]  paid,
    output logic [3:0]  remain,
    output logic [4:0]  change,
    output logic        dispense,
    output logic [15:0] stock,
    output logic [15:0] sold
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PAY      = 3'd1;
    localparam logic [2:0] S_DISPENSE = 3'd2;
    localparam logic [2:0] S_CHANGE   = 3'd3;
    localparam logic [2:0] S_REFUND   = 3'd4;
    localparam logic [2:0] S_SOLDOUT  = 3'd5;

    localparam logic [31:0] T_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] H_LAST = 32'(HOLD - 1);

    logic [2:0]  state_n;
    logic [3:0]  stk [4];
    logic [3:0]  sld [4];
    logic        armed;
    logic [31:0] timer;

    logic [31:0] timer_n;
    logic [4:0]  paid_n;
    logic [3:0]  remain_n;
    logic [4:0]  change_n;
    logic        dispense_n;

    logic        launch;
    logic [1:0]  sel_n;
    logic [3:0]  price_n;
    logic [3:0]  launch_stock;
    logic        coin_valid;
    logic [4:0]  coin_val;
    logic [4:0]  sum;
    logic        paid_done;
    logic        pay_cancel;
    logic        hold_done;

    assign stock = {stk[3], stk[2], stk[1], stk[0]};
    assign sold  = {sld[3], sld[2], sld[1], sld[0]};

    // Selection decode, coin decode and cancel/exit conditions.
    always_comb begin
        sel_n = 2'd0;
        if (sw[0])      sel_n = 2'd0;
        else if (sw[1]) sel_n = 2'd1;
        else if (sw[2]) sel_n = 2'd2;
        else if (sw[3]) sel_n = 2'd3;

        price_n = 4'(P1);
        unique case (sel_n)
            2'd0: price_n = 4'(P1);
            2'd1: price_n = 4'(P2);
            2'd2: price_n = 4'(P3);
            2'd3: price_n = 4'(P4);
        endcase

        launch       = (state == S_IDLE) && armed && (sw != 4'd0);
        launch_stock = restock ? 4'(STOCK_INIT) : stk[sel_n];

        coin_val = 5'd0;
        if (bt_edge[0])      coin_val = 5'd10;
        else if (bt_edge[1]) coin_val = 5'd5;
        else if (bt_edge[2]) coin_val = 5'd1;
        else if (bt_edge[4]) coin_val = 5'd2;

        coin_valid = $onehot({bt_edge[4], bt_edge[2:0]}) && !bt_edge[3];
        sum        = paid + coin_val;
        paid_done  = coin_valid && (sum >= {1'b0, price});
        pay_cancel = bt_edge[3] || (sw == 4'd0)
                     || (!coin_valid && (timer == T_LAST));
        hold_done  = bt_edge[3] || (timer == H_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (launch)
                    state_n = (launch_stock == 4'd0) ? S_SOLDOUT : S_PAY;
            end
            S_PAY: begin
                if (pay_cancel)
                    state_n = (paid != 5'd0) ? S_REFUND : S_IDLE;
                else if (paid_done)
                    state_n = S_DISPENSE;
            end
            S_DISPENSE: state_n = S_CHANGE;
            S_CHANGE, S_REFUND, S_SOLDOUT: begin
                if (hold_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered transaction outputs and timer.
    always_comb begin
        paid_n     = paid;
        remain_n   = remain;
        change_n   = change;
        timer_n    = timer + 32'd1;
        dispense_n = (state_n == S_DISPENSE);
        if (state_n != state || state == S_IDLE) timer_n = 32'd0;
        unique case (state)
            S_IDLE: begin
                if (launch && state_n == S_PAY) begin
                    paid_n   = 5'd0;
                    remain_n = price_n;
                end
            end
            S_PAY: begin
                if (state_n == S_REFUND) begin
                    change_n = paid;
                    remain_n = 4'd0;
                end else if (state_n == S_DISPENSE) begin
                    paid_n   = sum;
                    remain_n = 4'd0;
                    change_n = sum - {1'b0, price};
                end else if (coin_valid && state_n == S_PAY) begin
                    paid_n   = sum;
                    remain_n = remain - coin_val[3:0];
                    timer_n  = 32'd0;
                end
            end
            default: ;
        endcase
        if (state_n == S_IDLE) begin
            paid_n   = 5'd0;
            remain_n = 4'd0;
            change_n = 5'd0;
        end
    end

    // Datapath registers: selection, stock, sold, arming, timer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sel      <= 2'd0;
            price    <= 4'd0;
            paid     <= 5'd0;
            remain   <= 4'd0;
            change   <= 5'd0;
            dispense <= 1'b0;
            armed    <= 1'b1;
            timer    <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                stk[i] <= 4'(STOCK_INIT);
                sld[i] <= 4'd0;
            end
        end else begin
            paid     <= paid_n;
            remain   <= remain_n;
            change   <= change_n;
            dispense <= dispense_n;
            timer    <= timer_n;
            if (sw == 4'd0) armed <= 1'b1;
            else if (launch) armed <= 1'b0;
            if (launch) begin
                sel   <= sel_n;
                price <= price_n;
            end
            if (state == S_IDLE && restock) begin
                for (int i = 0; i < 4; i++) stk[i] <= 4'(STOCK_INIT);
            end
            if (state == S_DISPENSE) begin
                stk[sel] <= stk[sel] - 4'd1;
                if (sld[sel] != 4'hF) sld[sel] <= sld[sel] + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// tb_vend_txn_ctrl: directed plus random checks of vend_txn_ctrl
// against a transaction-rule reference model.
module tb_vend_txn_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  sw = 4'd0;
    logic [4:0]  bt = 5'd0;
    logic        restock = 1'b0;
    logic [2:0]  state;
    logic [1:0]  sel;
    logic [3:0]  price;
    logic [4:0]  paid;
    logic [3:0]  remain;
    logic [4:0]  change;
    logic        dispense;
    logic [15:0] stock;
    logic [15:0] sold;

    int checks = 0;
    int errors = 0;

    localparam int TO = 20;
    localparam int HD = 4;

    vend_txn_ctrl #(.TIMEOUT(TO), .HOLD(HD)) dut (
        .clk(clk), .rst_n(rst), .sw(sw), .bt_edge(bt),
        .restock(restock), .state(state), .sel(sel),
        .price(price), .paid(paid), .remain(remain),
        .change(change), .dispense(dispense),
        .stock(stock), .sold(sold)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers following the transaction rules.
    int prices [4] = '{12, 14, 2, 3};
    int m_state, m_sel, m_price, m_paid, m_remain, m_change, m_disp;
    int m_armed, m_cnt;
    int m_stock [4];
    int m_sold [4];

    task automatic m_reset();
        m_state = 0; m_sel = 0; m_price = 0; m_paid = 0;
        m_remain = 0; m_change = 0; m_disp = 0;
        m_armed = 1; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_stock[i] = 9;
            m_sold[i] = 0;
        end
    endtask

    task automatic m_step(input logic [3:0] s, input logic [4:0] b,
                          input logic r, input logic rs);
        int ns, ncoins, v, arm;
        bit valid;
        if (rs) begin
            m_reset();
            return;
        end
        ns = m_state;
        ncoins = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[4]);
        v = b[0] ? 10 : b[1] ? 5 : b[2] ? 1 : b[4] ? 2 : 0;
        valid = (ncoins == 1) && !b[3];
        arm = (s == 0) ? 1 : m_armed;
        case (m_state)
            0: begin
                if (r) for (int i = 0; i < 4; i++) m_stock[i] = 9;
                if (m_armed == 1 && s != 0) begin
                    m_sel = s[0] ? 0 : s[1] ? 1 : s[2] ? 2 : 3;
                    m_price = prices[m_sel];
                    arm = 0;
                    if (m_stock[m_sel] == 0) ns = 5;
                    else begin
                        ns = 1;
                        m_paid = 0;
                        m_remain = m_price;
                    end
                end
            end
            1: begin
                if (b[3] || s == 0 || (!valid && m_cnt + 1 == TO)) begin
                    if (m_paid > 0) begin
                        ns = 4;
                        m_change = m_paid;
                        m_remain = 0;
                    end else ns = 0;
                end else if (valid && m_paid + v >= m_price) begin
                    m_paid += v;
                    m_remain = 0;
                    m_change = m_paid - m_price;
                    ns = 2;
                end else if (valid) begin
                    m_paid += v;
                    m_remain -= v;
                    m_cnt = 0;
                end else m_cnt++;
            end
            2: begin
                m_stock[m_sel]--;
                if (m_sold[m_sel] < 15) m_sold[m_sel]++;
                ns = 3;
            end
            default: begin
                if (b[3] || m_cnt + 1 == HD) ns = 0;
                else m_cnt++;
            end
        endcase
        if (ns != m_state) m_cnt = 0;
        if (ns == 0) begin
            m_paid = 0; m_remain = 0; m_change = 0;
        end
        m_disp = (ns == 2) ? 1 : 0;
        m_state = ns;
        m_armed = arm;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        logic [15:0] es, eo;
        es = 16'd0;
        eo = 16'd0;
        for (int i = 0; i < 4; i++) begin
            es = es | (16'(m_stock[i]) << (4 * i));
            eo = eo | (16'(m_sold[i]) << (4 * i));
        end
        chk("state", 32'(state), 32'(m_state));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("price", 32'(price), 32'(m_price));
        chk("paid", 32'(paid), 32'(m_paid));
        chk("remain", 32'(remain), 32'(m_remain));
        chk("change", 32'(change), 32'(m_change));
        chk("dispense", 32'(dispense), 32'(m_disp));
        chk("stock", 32'(stock), 32'(es));
        chk("sold", 32'(sold), 32'(eo));
    endtask

    task automatic step(input logic [3:0] s, input logic [4:0] b,
                        input logic r = 1'b0, input logic rs = 1'b0);
        sw = s; bt = b; restock = r; rst = rs;
        @(posedge clk);
        m_step(s, b, r, rs);
        #1;
        cmp_model();
    endtask

    logic [3:0] cur_sw;
    logic [4:0] rb;
    int k;

    initial begin
        m_reset();
        #2;
        step(4'd0, 5'd0, 1'b0, 1'b1);
        step(4'd0, 5'd0, 1'b0, 1'b1);
        chk("rst_state", 32'(state), 0);
        chk("rst_stock", 32'(stock), 32'h9999);
        chk("rst_sold", 32'(sold), 0);

        // Exact sale of product 1.
        step(4'b0001, 5'd0);
        chk("sale_pay", 32'(state), 1);
        chk("sale_remain0", 32'(remain), 12);
        step(4'b0001, 5'b00001);
        chk("sale_remain1", 32'(remain), 2);
        step(4'b0001, 5'b10000);
        chk("sale_disp_state", 32'(state), 2);
        chk("sale_disp", 32'(dispense), 1);
        chk("sale_paid", 32'(paid), 12);
        chk("sale_change", 32'(change), 0);
        step(4'b0001, 5'd0);
        chk("sale_change_st", 32'(state), 3);
        chk("sale_disp_off", 32'(dispense), 0);
        chk("sale_stock1", 32'(stock[3:0]), 8);
        chk("sale_sold1", 32'(sold[3:0]), 1);
        repeat (3) step(4'b0001, 5'd0);
        chk("sale_hold", 32'(state), 3);
        step(4'b0001, 5'd0);
        chk("sale_idle", 32'(state), 0);
        step(4'b0001, 5'd0);
        chk("sale_norelaunch", 32'(state), 0);
        step(4'd0, 5'd0);

        // Overpay on product 4.
        step(4'b1000, 5'd0);
        step(4'b1000, 5'b00010);
        chk("over_paid", 32'(paid), 5);
        chk("over_change", 32'(change), 2);
        chk("over_disp", 32'(dispense), 1);
        step(4'd0, 5'd0);
        chk("over_stock4", 32'(stock[15:12]), 8);
        repeat (3) step(4'd0, 5'd0);
        chk("over_change_hold", 32'(change), 2);
        step(4'd0, 5'd0);
        chk("over_change_clr", 32'(change), 0);

        // Cancel and refund, then switch-drop refund.
        for (int pass = 0; pass < 2; pass++) begin
            step(4'b0010, 5'd0);
            step(4'b0010, 5'b00001);
            step(4'b0010, 5'b00100);
            if (pass == 0) step(4'b0010, 5'b01000);
            else step(4'd0, 5'd0);
            chk("ref_state", 32'(state), 4);
            chk("ref_change", 32'(change), 11);
            chk("ref_stock2", 32'(stock[7:4]), 9);
            chk("ref_sold2", 32'(sold[7:4]), 0);
            step(4'd0, 5'b01000);
            chk("ref_ack", 32'(state), 0);
        end

        // Timeout with and without coins.
        step(4'b0001, 5'd0);
        step(4'b0001, 5'b10000);
        repeat (TO - 1) step(4'b0001, 5'd0);
        chk("to_still_pay", 32'(state), 1);
        step(4'b0001, 5'd0);
        chk("to_refund", 32'(state), 4);
        chk("to_change", 32'(change), 2);
        repeat (HD) step(4'd0, 5'd0);
        step(4'b0001, 5'd0);
        repeat (TO - 1) step(4'b0001, 5'd0);
        chk("to0_still_pay", 32'(state), 1);
        step(4'b0001, 5'd0);
        chk("to0_idle", 32'(state), 0);
        step(4'd0, 5'd0);

        // Nine sales of product 3, then sold out and restock.
        repeat (9) begin
            step(4'b0100, 5'd0);
            step(4'b0100, 5'b10000);
            step(4'd0, 5'd0);
            step(4'd0, 5'b01000);
        end
        chk("so_stock3", 32'(stock[11:8]), 0);
        chk("so_sold3", 32'(sold[11:8]), 9);
        step(4'b0100, 5'd0);
        chk("so_state", 32'(state), 5);
        chk("so_nodisp", 32'(dispense), 0);
        repeat (HD) step(4'b0100, 5'd0);
        chk("so_idle", 32'(state), 0);
        step(4'b0100, 5'd0);
        chk("so_held", 32'(state), 0);
        step(4'd0, 5'd0, 1'b1);
        chk("so_restock", 32'(stock[11:8]), 9);

        // Multi-coin discard and coin plus cancel.
        step(4'b0001, 5'd0);
        step(4'b0001, 5'b10100);
        chk("multi_paid", 32'(paid), 0);
        step(4'b0001, 5'b00100);
        step(4'b0001, 5'b01001);
        chk("cc_state", 32'(state), 4);
        chk("cc_change", 32'(change), 1);
        step(4'd0, 5'b01000);

        // Reset during PAY.
        step(4'b0001, 5'd0);
        step(4'b0001, 5'b00001);
        step(4'b0001, 5'd0, 1'b0, 1'b1);
        chk("rpay_state", 32'(state), 0);
        chk("rpay_paid", 32'(paid), 0);
        chk("rpay_stock", 32'(stock), 32'h9999);
        step(4'd0, 5'd0);

        // Sold counter saturation on product 4.
        repeat (16) begin
            step(4'b1000, 5'd0);
            step(4'b1000, 5'b00010);
            step(4'd0, 5'd0);
            step(4'd0, 5'b01000);
            step(4'd0, 5'd0, 1'b1);
        end
        chk("sat_sold4", 32'(sold[15:12]), 15);

        // Random traffic against the model.
        cur_sw = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(2) == 0) cur_sw = 4'd0;
                else cur_sw = 4'($urandom_range(15));
            end
            k = $urandom_range(11);
            rb = 5'd0;
            if (k == 0) rb = 5'b00001;
            else if (k == 1) rb = 5'b00010;
            else if (k == 2) rb = 5'b00100;
            else if (k == 3) rb = 5'b10000;
            else if (k == 4) rb = 5'b01000;
            else if (k == 5) rb = 5'($urandom_range(31));
            step(cur_sw, rb, $urandom_range(19) == 0,
                 $urandom_range(499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
